// File: rtl/exec_pkg.sv
// Shared encodings for the execute datapath.
//   alu_op_e   : ALU function select (3 bits)
//   op_kind_e  : operation class (2 bits)
//   state_e    : control FSM states
//   is_mem_op  : true for the classes that go through the memory stage
package exec_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_XOR = 3'd2,
    ALU_NOR = 3'd3,
    ALU_ADD = 3'd4,
    ALU_SUB = 3'd5,
    ALU_SLT = 3'd6,
    ALU_SLL = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    OP_ALU     = 2'd0,
    OP_LOAD    = 2'd1,
    OP_STORE   = 2'd2,
    OP_ILLEGAL = 2'd3
  } op_kind_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MEM  = 2'd2,
    WB   = 2'd3
  } state_e;

  function automatic logic is_mem_op(op_kind_e k);
    return (k == OP_LOAD) || (k == OP_STORE);
  endfunction

endpackage

// File: rtl/exec_datapath_alu_unit.sv
// Combinational ALU for the execute datapath.
//   a, b : operands (a from the register file, b the extended immediate)
//   op   : function select
//   f    : result
//   zf   : f == 0
//   of   : signed overflow, only meaningful for add/sub (0 otherwise)
module alu_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] f,
  output logic             zf,
  output logic             of
);

  localparam int SH_W = $clog2(WIDTH);

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic        [WIDTH-1:0] sum;
  logic        [WIDTH-1:0] diff;
  logic                    of_add;
  logic                    of_sub;

  assign a_s  = a;
  assign b_s  = b;
  assign sum  = a + b;
  assign diff = a - b;

  // Overflow when the operand signs make the true result unrepresentable
  // and the wrapped result's sign disagrees with operand A.
  assign of_add = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1]  != a[WIDTH-1]);
  assign of_sub = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    f  = '0;
    of = 1'b0;
    case (op)
      ALU_AND: f = a & b;
      ALU_OR:  f = a | b;
      ALU_XOR: f = a ^ b;
      ALU_NOR: f = ~(a | b);
      ALU_ADD: begin
        f  = sum;
        of = of_add;
      end
      ALU_SUB: begin
        f  = diff;
        of = of_sub;
      end
      ALU_SLT: f = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      ALU_SLL: f = a << b[SH_W-1:0];
      default: f = '0;
    endcase
  end

  assign zf = (f == '0);

endmodule

// File: rtl/exec_datapath.sv
// Multi-cycle execute datapath: register file, immediate ALU and a word
// memory sequenced by a four-state FSM (IDLE -> EXEC -> [MEM] -> WB).
//   clk, rst_n        : clock, synchronous active-low reset
//   start             : issue request, honoured only while busy=0
//   op_kind, alu_op   : operation class and ALU function
//   rs, rt, rd        : source A, store-data source, destination
//   imm               : immediate operand B / address offset
//   busy, done        : in-flight indicator, one-cycle completion pulse
//   err               : last op faulted (misaligned or illegal)
//   result, zf, of    : registered ALU output and flags
//   dbg_addr/dbg_data : combinational register file read port
module exec_datapath
  import exec_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MEM_ADDR_W = 6,
  parameter int IMM_W      = 16,
  parameter int SIGN_EXT   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            op_kind,
  input  logic [2:0]            alu_op,
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [REG_ADDR_W-1:0] rt,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [IMM_W-1:0]      imm,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [WIDTH-1:0]      result,
  output logic                  zf,
  output logic                  of,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]      dbg_data
);

  localparam int NREGS = 2**REG_ADDR_W;
  localparam int DEPTH = 2**MEM_ADDR_W;

  function automatic logic [WIDTH-1:0] ext_imm(input logic [IMM_W-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    r[IMM_W-1:0] = v;
    for (int i = IMM_W; i < WIDTH; i++) r[i] = (SIGN_EXT != 0) && v[IMM_W-1];
    return r;
  endfunction

  state_e state;
  state_e state_nx;
  logic   accept;

  op_kind_e              op_kind_p0;
  alu_op_e               alu_op_p0;
  logic [REG_ADDR_W-1:0] rs_p0;
  logic [REG_ADDR_W-1:0] rt_p0;
  logic [REG_ADDR_W-1:0] rd_p0;
  logic [IMM_W-1:0]      imm_p0;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] mem  [DEPTH];
  logic [WIDTH-1:0] mem_q;

  logic [WIDTH-1:0]      opa;
  logic [WIDTH-1:0]      opb;
  logic [WIDTH-1:0]      sdata;
  alu_op_e               alu_sel;
  logic [WIDTH-1:0]      alu_f;
  logic                  alu_zf;
  logic                  alu_of;
  logic                  fault;
  logic [MEM_ADDR_W-1:0] waddr;
  logic                  mem_we;
  logic                  reg_we;
  logic [WIDTH-1:0]      reg_wdata;

  // Register 0 is hard-wired to zero on every read port.
  function automatic logic [WIDTH-1:0] rf_read(input logic [REG_ADDR_W-1:0] a);
    return (a == '0) ? '0 : regs[a];
  endfunction

  // Control FSM
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC:    state_nx = is_mem_op(op_kind_p0) ? MEM : WB;
      MEM:     state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == WB);

  // Issue stage: operands latched at accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_kind_p0 <= OP_ALU;
      alu_op_p0  <= ALU_AND;
      rs_p0      <= '0;
      rt_p0      <= '0;
      rd_p0      <= '0;
      imm_p0     <= '0;
    end else if (accept) begin
      op_kind_p0 <= op_kind_e'(op_kind);
      alu_op_p0  <= alu_op_e'(alu_op);
      rs_p0      <= rs;
      rt_p0      <= rt;
      rd_p0      <= rd;
      imm_p0     <= imm;
    end
  end

  // Execute stage: compute and register result/flags/fault
  assign opa     = rf_read(rs_p0);
  assign opb     = ext_imm(imm_p0);
  assign alu_sel = is_mem_op(op_kind_p0) ? ALU_ADD : alu_op_p0;

  alu_unit #(.WIDTH(WIDTH)) u_alu (
    .a  (opa),
    .b  (opb),
    .op (alu_sel),
    .f  (alu_f),
    .zf (alu_zf),
    .of (alu_of)
  );

  assign fault = (op_kind_p0 == OP_ILLEGAL) ||
                 (is_mem_op(op_kind_p0) && (alu_f[1:0] != 2'b00));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      zf     <= 1'b0;
      of     <= 1'b0;
      err    <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (state == EXEC) begin
      result <= alu_f;
      zf     <= alu_zf;
      of     <= alu_of;
      err    <= fault;
    end
  end

  // Memory stage: single-port, read-first, one-cycle read latency.
  // The write enable is gated by rst_n so a reset landing on a store aborts it.
  assign waddr  = result[MEM_ADDR_W+1:2];
  assign sdata  = rf_read(rt_p0);
  assign mem_we = rst_n && (state == MEM) && (op_kind_p0 == OP_STORE) && !err;

  always_ff @(posedge clk) begin
    if (mem_we) mem[waddr] <= sdata;
    mem_q <= mem[waddr];
  end

  // Writeback stage: commit to the register file at the edge ending WB
  assign reg_we    = (state == WB) && !err && (rd_p0 != '0) &&
                     ((op_kind_p0 == OP_ALU) || (op_kind_p0 == OP_LOAD));
  assign reg_wdata = (op_kind_p0 == OP_LOAD) ? mem_q : result;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[rd_p0] <= reg_wdata;
    end
  end

  assign dbg_data = rf_read(dbg_addr);

endmodule

// File: tb/tb_exec_datapath.sv
module tb_exec_datapath;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op_kind = '0;
  logic [2:0]  alu_op = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, dbg_addr = '0;
  logic [15:0] imm = '0;
  logic        busy, done, err, zf, of;
  logic [31:0] result, dbg_data;

  exec_datapath #(
    .WIDTH(32), .REG_ADDR_W(5), .MEM_ADDR_W(6), .IMM_W(16), .SIGN_EXT(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_kind(op_kind), .alu_op(alu_op),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .busy(busy), .done(done), .err(err),
    .result(result), .zf(zf), .of(of), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int dones = 0;
  int accepts = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Architectural reference state
  logic [31:0] mreg [32];
  logic [31:0] mmem [64];

  typedef struct {
    logic [31:0] res;
    logic        zf;
    logic        of;
    logic        err;
    bit          chk_res;
    bit          chk_of;
  } exp_t;

  exp_t q[$];

  function automatic exp_t predict(input int kind, input int aop,
                                   input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.res = '0; e.of = 1'b0; e.err = 1'b0; e.chk_res = 1'b1; e.chk_of = 1'b1;
    case (kind)
      0: begin
        case (aop)
          0: e.res = a & b;
          1: e.res = a | b;
          2: e.res = a ^ b;
          3: e.res = ~(a | b);
          4: begin
            s = sa + sb;
            e.res = s[31:0];
            e.of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
          end
          5: begin
            s = sa - sb;
            e.res = s[31:0];
            e.of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
          end
          6: e.res = (sa < sb) ? 32'd1 : 32'd0;
          default: e.res = a << (b % 32);
        endcase
      end
      1, 2: begin
        e.res = a + b;
        e.err = (e.res % 4) != 0;
        e.chk_of = 1'b0;
      end
      default: begin
        e.err = 1'b1;
        e.chk_res = 1'b0;
        e.chk_of = 1'b0;
      end
    endcase
    e.zf = (e.res == 32'd0);
    return e;
  endfunction

  // Monitor: every done pulse consumes one expected completion
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      dones++;
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: got done=1 expected no completion (t=%0t)", $time);
      end else begin
        e = q.pop_front();
        chk("err", {31'd0, err}, {31'd0, e.err});
        if (e.chk_res) begin
          chk("result", result, e.res);
          chk("zf", {31'd0, zf}, {31'd0, e.zf});
        end
        if (e.chk_of) chk("of", {31'd0, of}, {31'd0, e.of});
      end
    end
  end

  task automatic predict_and_commit(input int kind, input int aop, input int s, input int t,
                                    input int d, input logic [15:0] im, output exp_t e);
    int wa;
    e = predict(kind, aop, mreg[s], {16'h0000, im});
    q.push_back(e);
    wa = int'(e.res[7:2]);
    if (!e.err) begin
      case (kind)
        0: if (d != 0) mreg[d] = e.res;
        1: if (d != 0) mreg[d] = mmem[wa];
        2: mmem[wa] = mreg[t];
        default: ;
      endcase
    end
  endtask

  task automatic drive(input int kind, input int aop, input int s, input int t,
                       input int d, input logic [15:0] im);
    op_kind = kind[1:0];
    alu_op  = aop[2:0];
    rs = s[4:0]; rt = t[4:0]; rd = d[4:0];
    imm = im;
    start = 1'b1;
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic issue(input int kind, input int aop, input int s, input int t,
                       input int d, input logic [15:0] im, input bit poke);
    exp_t e;
    int   lat;
    predict_and_commit(kind, aop, s, t, d, im, e);
    dbg_addr = d[4:0];
    drive(kind, aop, s, t, d, im);
    @(posedge clk);
    #1 start = 1'b0;
    accepts++;
    @(negedge clk);
    chk("busy_exec", {31'd0, busy}, 32'd1);
    chk("err_cleared_on_accept", {31'd0, err}, 32'd0);
    if (poke) begin
      rd = 5'd9; imm = 16'hABCD; alu_op = 3'd1;
      start = 1'b1;
    end
    lat = 0;
    while (!done && lat < 8) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    start = 1'b0;
    chk("latency", lat, (kind == 1 || kind == 2) ? 32'd2 : 32'd1);
    @(negedge clk);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("err_held", {31'd0, err}, {31'd0, e.err});
    chk("dbg_rd", dbg_data, mreg[d]);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"},   {31'd0, busy}, 32'd0);
    chk({tag, "_done"},   {31'd0, done}, 32'd0);
    chk({tag, "_err"},    {31'd0, err},  32'd0);
    chk({tag, "_result"}, result,        32'd0);
    chk({tag, "_zf"},     {31'd0, zf},   32'd0);
    chk({tag, "_of"},     {31'd0, of},   32'd0);
  endtask

  initial begin
    exp_t e;
    int   kind, aop, s, t, d;
    logic [15:0] im;

    for (int i = 0; i < 32; i++) mreg[i] = '0;
    for (int i = 0; i < 64; i++) mmem[i] = '0;

    // Reset, with start held high to confirm it is dropped
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check_cleared("reset");
    dbg_addr = 5'd5;
    #1 chk("reset_dbg_r5", dbg_data, 32'd0);
    rst_n = 1'b1;

    // Directed sequence
    issue(0, 4, 0, 0, 5, 16'h1234, 0);   // r5 = 0x1234
    issue(0, 3, 0, 0, 2, 16'h0000, 0);   // r2 = ~0
    issue(0, 1, 0, 0, 3, 16'h0001, 0);   // r3 = 1
    issue(0, 7, 3, 0, 4, 16'd31,   0);   // r4 = 0x8000_0000
    issue(0, 5, 4, 0, 1, 16'h0001, 0);   // r1 = 0x7FFF_FFFF, overflow
    issue(2, 0, 0, 1, 0, 16'h0010, 0);   // mem[0x10] = r1
    issue(1, 0, 0, 0, 10, 16'h0010, 0);  // r10 = mem[0x10]
    issue(0, 4, 10, 0, 11, 16'h0001, 0); // 0x7FFF_FFFF + 1 overflows
    issue(0, 5, 0, 0, 12, 16'h0000, 0);  // zero result, no overflow
    issue(0, 6, 2, 0, 16, 16'h0001, 0);  // -1 < 1 signed
    issue(2, 0, 0, 5, 0, 16'h0008, 0);   // mem[8] = r5
    issue(1, 0, 0, 0, 6, 16'h0008, 0);   // r6 = mem[8]
    issue(1, 0, 0, 0, 8, 16'h0006, 0);   // misaligned load
    issue(3, 0, 0, 0, 13, 16'h0005, 0);  // illegal
    issue(0, 0, 5, 0, 14, 16'hFFFF, 0);  // err clears on this accept
    issue(0, 2, 5, 0, 15, 16'h00F0, 1);  // start pulsed while busy
    dbg_addr = 5'd9;
    #1 chk("poke_r9_untouched", dbg_data, mreg[9]);

    // Reset landing in the WB cycle of an ALU op to r7
    predict_and_commit(0, 4, 0, 0, 7, 16'h0055, e);
    dbg_addr = 5'd7;
    drive(0, 4, 0, 0, 7, 16'h0055);
    @(posedge clk);
    #1 start = 1'b0;
    accepts++;
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_wb", {31'd0, done}, 32'd1);
    rst_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) mreg[i] = '0;
    check_cleared("abort");
    chk("abort_r7", dbg_data, 32'd0);
    @(negedge clk);
    chk("reset_start_dropped", {31'd0, busy}, 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    issue(0, 4, 0, 0, 5, 16'h0077, 0);

    // Randomised register contents, then a fully known memory image
    for (int n = 0; n < 40; n++) begin
      issue(0, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)), 0,
            int'($urandom_range(1, 31)), 16'($urandom), 0);
    end
    for (int w = 0; w < 64; w++) begin
      issue(2, 0, 0, int'($urandom_range(0, 31)), 0, 16'(w * 4), 0);
    end

    // Randomised mixed traffic
    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom_range(0, 9));
      kind = (kind < 5) ? 0 : (kind < 7) ? 1 : (kind < 9) ? 2 : 3;
      aop  = int'($urandom_range(0, 7));
      s    = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 31));
      t    = int'($urandom_range(0, 31));
      d    = int'($urandom_range(0, 31));
      im   = 16'($urandom);
      if (kind != 0 && $urandom_range(0, 3) != 0) im = im & 16'hFFFC;
      issue(kind, aop, s, t, d, im, ($urandom_range(0, 7) == 0));
    end

    chk("done_count", dones, accepts);
    chk("queue_drained", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
